// File: rtl/lsu_pkg.sv
// Shared encodings, widths and FSM state type for the load/store initiator.
package lsu_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  // Byte accesses can never be misaligned; reserved size behaves as a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = off[0];
      default: is_misaligned = |off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// Little-endian byte-lane steering: merge store data into a memory word, and
// extract plus sign/zero-extend load data from a memory word.
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        size,
  input  logic [1:0]        byte_off,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] merged,
  output logic [DATA_W-1:0] rdata
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  assign load_byte = word[{byte_off, 3'b000} +: 8];
  assign load_half = byte_off[1] ? word[31:16] : word[15:0];

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    merged = word;
    case (size)
      SZ_BYTE: merged[{byte_off, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (byte_off[1]) merged[31:16] = wdata[15:0];
        else             merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

  always_comb begin
    rdata = word;
    case (size)
      SZ_BYTE: rdata = is_unsigned ? {24'd0, load_byte} : {{24{load_byte[7]}}, load_byte};
      SZ_HALF: rdata = is_unsigned ? {16'd0, load_half} : {{16{load_half[15]}}, load_half};
      default: rdata = word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator to a word-addressed memory; sub-word stores use read-modify-write.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_misalign,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  lsu_state_t    state_q, state_d;
  logic          write_q;
  logic          unsigned_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] word_q;
  logic [DW-1:0] merged_word;
  logic [DW-1:0] load_data;
  logic          accept;
  logic          req_is_word;
  logic          trapped;

  assign req_ready   = (state_q == IDLE);
  assign accept      = req_valid && req_ready;
  assign req_is_word = req_size inside {SZ_WORD, SZ_RSVD};

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q;
  logic req_misalign;

  assign req_misalign = is_misaligned(req_size, req_addr[1:0]);
  assign trapped      = misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      misalign_q <= 1'b0;
    else if (accept) misalign_q <= req_misalign;
  end
`else
  assign trapped = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef LSU_MISALIGN_TRAP_EN
          if (req_misalign) state_d = RESP;
          else
`endif
          if (req_write && req_is_word) state_d = WR;
          else                          state_d = RD;
        end
      end
      RD:      state_d = write_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= SZ_BYTE;
      addr_q     <= '0;
      wdata_q    <= '0;
      word_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q    <= req_write;
        unsigned_q <= req_unsigned;
        size_q     <= req_size;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
      end
      if (state_q == RD) word_q <= mem_rdata;
    end
  end

  lsu_lane_mux u_lane_mux (
    .word        (word_q),
    .wdata       (wdata_q),
    .size        (size_q),
    .byte_off    (addr_q[1:0]),
    .is_unsigned (unsigned_q),
    .merged      (merged_word),
    .rdata       (load_data)
  );

  // Outputs decode straight from state so an async reset drops mem_write immediately.
  assign mem_write     = (state_q == WR);
  assign mem_wdata     = (state_q == WR) ? merged_word : '0;
  assign mem_addr      = ((state_q != IDLE) && !trapped) ? {addr_q[AW-1:2], 2'b00} : '0;
  assign resp_valid    = (state_q == RESP);
  assign resp_rdata    = ((state_q == RESP) && !write_q && !trapped) ? load_data : '0;
  assign resp_misalign = (state_q == RESP) && trapped;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: the stimulus pushes expected responses and
// writes, a negedge monitor pops and compares them. Honours LSU_MISALIGN_TRAP_EN.
module tb_lsu_mem_master;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_misalign, mem_write;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:255];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          cyc;
  } resp_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_exp_t;

  resp_exp_t resp_q[$];
  wr_exp_t   wr_q[$];

  lsu_mem_master dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_misalign (resp_misalign),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(negedge clk) begin
    if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response and every write strobe must match a queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (resp_valid) begin
        if (resp_q.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          resp_exp_t e;
          e = resp_q.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_misalign", {31'd0, resp_misalign}, {31'd0, e.mis});
          check("resp_cycle", cyc, e.cyc);
        end
      end
      if (mem_write) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", mem_addr, 32'hFFFF_FFFF);
        end else begin
          wr_exp_t w;
          w = wr_q.pop_front();
          check("mem_addr_wr", mem_addr, w.addr);
          check("mem_wdata", mem_wdata, w.data);
        end
      end
    end
  end

  // Issues one request; lat is the cycle (1 = first cycle after the accepting edge)
  // in which resp_valid must appear.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_mis, input int lat,
                       input logic exp_wr, input logic [31:0] exp_wd, input logic push,
                       output int stalls, output int acc_cyc);
    bit ok = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_size = sz;
    req_unsigned = uns;
    req_addr = addr;
    req_wdata = wd;
    stalls = 0;
    if (push && exp_wr) wr_q.push_back('{addr: {addr[31:2], 2'b00}, data: exp_wd});
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin
        @(posedge clk);
        ok = 1;
        break;
      end
      stalls++;
      @(negedge clk);
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
    if (push) resp_q.push_back('{rdata: exp_rd, mis: exp_mis, cyc: acc_cyc + lat - 1});
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (resp_q.size() == 0 && wr_q.size() == 0) return;
      @(negedge clk);
    end
    check("drain_timeout", resp_q.size() + wr_q.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    check({tag, "_resp_misalign"}, {31'd0, resp_misalign}, 32'd0);
    check({tag, "_mem_write"}, {31'd0, mem_write}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int st, a0, a1;
    for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
    mem[8'h08] <= 32'h1122_3344;
    mem[8'h0C] <= 32'h80FF_7F01;
    mem[8'h10] <= 32'hCAFE_F00D;
    mem[8'h14] <= 32'h1122_3344;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = SZ_BYTE;
    req_unsigned = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;

    // word store then word load
    issue(1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 1, 32'hDEADBEEF, 1, st, a0);
    issue(0, SZ_WORD, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2, 0, 32'h0, 1, st, a0);
    // sub-word read-modify-write stores
    issue(1, SZ_BYTE, 0, 32'h22, 32'h000000AA, 32'h0, 0, 3, 1, 32'h11AA3344, 1, st, a0);
    issue(0, SZ_WORD, 0, 32'h20, 32'h0, 32'h11AA3344, 0, 2, 0, 32'h0, 1, st, a0);
    issue(1, SZ_HALF, 0, 32'h22, 32'h1234BEEF, 32'h0, 0, 3, 1, 32'hBEEF3344, 1, st, a0);
    issue(0, SZ_WORD, 0, 32'h20, 32'h0, 32'hBEEF3344, 0, 2, 0, 32'h0, 1, st, a0);
    // extension cases against 0x80FF7F01
    issue(0, SZ_BYTE, 0, 32'h33, 32'h0, 32'hFFFFFF80, 0, 2, 0, 32'h0, 1, st, a0);
    issue(0, SZ_BYTE, 1, 32'h33, 32'h0, 32'h00000080, 0, 2, 0, 32'h0, 1, st, a0);
    issue(0, SZ_HALF, 0, 32'h30, 32'h0, 32'h00007F01, 0, 2, 0, 32'h0, 1, st, a0);
    issue(0, SZ_HALF, 0, 32'h32, 32'h0, 32'hFFFF80FF, 0, 2, 0, 32'h0, 1, st, a0);
    issue(0, SZ_HALF, 1, 32'h32, 32'h0, 32'h000080FF, 0, 2, 0, 32'h0, 1, st, a0);
    issue(0, SZ_BYTE, 0, 32'h31, 32'h0, 32'h0000007F, 0, 2, 0, 32'h0, 1, st, a0);
    issue(0, SZ_BYTE, 0, 32'h32, 32'h0, 32'hFFFFFFFF, 0, 2, 0, 32'h0, 1, st, a0);
    issue(0, SZ_RSVD, 0, 32'h30, 32'h0, 32'h80FF7F01, 0, 2, 0, 32'h0, 1, st, a0);

    // back-to-back: second request waits out RD/WR/RESP of a sub-word store
    issue(1, SZ_BYTE, 0, 32'h34, 32'h00000077, 32'h0, 0, 3, 1, 32'h00000077, 1, st, a0);
    issue(0, SZ_BYTE, 1, 32'h34, 32'h0, 32'h00000077, 0, 2, 0, 32'h0, 1, st, a1);
    check("busy_stalls", st, 32'd3);
    check("reaccept_gap", a1 - a0, 32'd4);
    issue(1, SZ_BYTE, 0, 32'h37, 32'h0000005A, 32'h0, 0, 3, 1, 32'h5A000077, 1, st, a0);
    issue(0, SZ_WORD, 0, 32'h34, 32'h0, 32'h5A000077, 0, 2, 0, 32'h0, 1, st, a0);
    drain();

    // reset asserted while the sb sits in RD
    issue(1, SZ_BYTE, 0, 32'h50, 32'h00000099, 32'h0, 0, 3, 0, 32'h0, 0, st, a0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    check("post_rst_mem", mem[8'h14], 32'h11223344);
    issue(0, SZ_WORD, 0, 32'h50, 32'h0, 32'h11223344, 0, 2, 0, 32'h0, 1, st, a0);

`ifdef LSU_MISALIGN_TRAP_EN
    issue(0, SZ_WORD, 0, 32'h41, 32'h0, 32'h0, 1, 1, 0, 32'h0, 1, st, a0);
    issue(0, SZ_HALF, 0, 32'h43, 32'h0, 32'h0, 1, 1, 0, 32'h0, 1, st, a0);
    issue(1, SZ_WORD, 0, 32'h42, 32'h12345678, 32'h0, 1, 1, 0, 32'h0, 1, st, a0);
    issue(0, SZ_BYTE, 1, 32'h43, 32'h0, 32'h000000CA, 0, 2, 0, 32'h0, 1, st, a0);
`else
    issue(0, SZ_WORD, 0, 32'h41, 32'h0, 32'hCAFEF00D, 0, 2, 0, 32'h0, 1, st, a0);
    issue(0, SZ_HALF, 0, 32'h43, 32'h0, 32'hFFFFCAFE, 0, 2, 0, 32'h0, 1, st, a0);
    issue(0, SZ_HALF, 1, 32'h41, 32'h0, 32'h0000F00D, 0, 2, 0, 32'h0, 1, st, a0);
`endif
    drain();
    check("mem_0x40_intact", mem[8'h10], 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
